// File: rtl/icache_pkg.sv
// Shared widths and constants for the instruction cache slice.
package icache_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned REG_LEN  = 32;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [REG_LEN-1:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [ADDR_LEN-1:0] addr_t;
    typedef logic [REG_LEN-1:0]  word_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data, combinational read, synchronous write.
module icache_array
    import icache_pkg::*;
#(
    parameter  int unsigned INDEX_BITS = 6,
    localparam int unsigned TAG_BITS   = ADDR_LEN - INDEX_BITS - 2,
    localparam int unsigned DEPTH      = 1 << INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid_c,
    output logic [TAG_BITS-1:0]   rd_tag_c,
    output word_t                 rd_data_c,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  word_t                 wr_data
);

    logic [DEPTH-1:0]    valid;
    logic [TAG_BITS-1:0] tags [DEPTH];
    word_t               data [DEPTH];

    // Only the valid bits are reset; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (rdy && wr_en) begin
            valid[wr_index] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy && wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid_c = valid[rd_index];
    assign rd_tag_c   = tags[rd_index];
    assign rd_data_c  = data[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache between IF and MemCtrl.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rdy,
    input  logic  if_req_i,
    input  addr_t if_pc_i,
    input  logic  if_jump_i,
    output logic  inst_valid_o,
    output word_t inst_o,
    output logic  busy_o,
    output logic  mem_req_o,
    output addr_t mem_pc_o,
    output logic  mem_jump_o,
    input  logic  mem_inst_ready_i,
    input  word_t mem_inst_i
);

    localparam int unsigned TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state, state_n;
    addr_t  miss_pc, miss_pc_n;
    logic   inst_valid_n, busy_n, mem_req_n, mem_jump_n;
    word_t  inst_n;
    addr_t  mem_pc_n;

    logic                rd_valid_c;
    logic [TAG_BITS-1:0] rd_tag_c;
    word_t               rd_data_c;
    logic                hit_c;
    logic                wr_en_c;

    icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rd_index   (if_pc_i[INDEX_BITS+1:2]),
        .rd_valid_c (rd_valid_c),
        .rd_tag_c   (rd_tag_c),
        .rd_data_c  (rd_data_c),
        .wr_en      (wr_en_c),
        .wr_index   (miss_pc[INDEX_BITS+1:2]),
        .wr_tag     (miss_pc[ADDR_LEN-1:INDEX_BITS+2]),
        .wr_data    (mem_inst_i)
    );

    assign hit_c = rd_valid_c && (rd_tag_c == if_pc_i[ADDR_LEN-1:INDEX_BITS+2]);

    // State and registered outputs; rdy low freezes everything except reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            miss_pc      <= ZERO_WORD;
            inst_valid_o <= DISABLE;
            inst_o       <= ZERO_WORD;
            busy_o       <= DISABLE;
            mem_req_o    <= DISABLE;
            mem_pc_o     <= ZERO_WORD;
            mem_jump_o   <= DISABLE;
        end else if (rdy) begin
            state        <= state_n;
            miss_pc      <= miss_pc_n;
            inst_valid_o <= inst_valid_n;
            inst_o       <= inst_n;
            busy_o       <= busy_n;
            mem_req_o    <= mem_req_n;
            mem_pc_o     <= mem_pc_n;
            mem_jump_o   <= mem_jump_n;
        end
    end

    // Next state / next outputs; a redirect overrides everything but a landing fill.
    always_comb begin
        state_n      = state;
        miss_pc_n    = miss_pc;
        inst_valid_n = DISABLE;
        inst_n       = inst_o;
        busy_n       = DISABLE;
        mem_req_n    = DISABLE;
        mem_pc_n     = mem_pc_o;
        mem_jump_n   = DISABLE;
        wr_en_c      = DISABLE;

        if (if_jump_i) begin
            state_n    = IDLE;
            mem_jump_n = ENABLE;
            wr_en_c    = (state == MISS) && mem_inst_ready_i;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req_i) begin
                        if (hit_c) begin
                            inst_valid_n = ENABLE;
                            inst_n       = rd_data_c;
                        end else begin
                            state_n   = MISS;
                            miss_pc_n = if_pc_i;
                            mem_req_n = ENABLE;
                            mem_pc_n  = if_pc_i;
                            busy_n    = ENABLE;
                        end
                    end
                end
                MISS: begin
                    if (mem_inst_ready_i) begin
                        state_n      = IDLE;
                        wr_en_c      = ENABLE;
                        inst_valid_n = ENABLE;
                        inst_n       = mem_inst_i;
                    end else begin
                        mem_req_n = ENABLE;
                        mem_pc_n  = miss_pc;
                        busy_n    = ENABLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: scenario tasks plus an instruction scoreboard.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic        if_jump_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_pc_o;
    logic        mem_jump_o;
    logic        mem_inst_ready_i;
    logic [31:0] mem_inst_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    icache #(.INDEX_BITS(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .if_req_i         (if_req_i),
        .if_pc_i          (if_pc_i),
        .if_jump_i        (if_jump_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .busy_o           (busy_o),
        .mem_req_o        (mem_req_o),
        .mem_pc_o         (mem_pc_o),
        .mem_jump_o       (mem_jump_o),
        .mem_inst_ready_i (mem_inst_ready_i),
        .mem_inst_i       (mem_inst_i)
    );

    always #5 clk = ~clk;

    // Scoreboard: each delivered instruction (counted once, on the cycle rdy lets it go).
    always @(negedge clk) begin
        if (rst && rdy) begin
            if (inst_valid_o && mem_jump_o) begin
                checks++;
                errors++;
                $display("FAIL excl: inst_valid_o and mem_jump_o both high at %0t", $time);
            end
            if (inst_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: inst_valid_o=1 inst_o=%h, expected no delivery", inst_o);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (inst_o !== e) begin
                        errors++;
                        $display("FAIL sb_inst: got %h expected %h", inst_o, e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i         = 1'b0;
        if_jump_i        = 1'b0;
        mem_inst_ready_i = 1'b0;
    endtask

    // Full miss: request, one held miss cycle, then MemCtrl completion.
    task automatic fill(input logic [31:0] pc, input logic [31:0] data);
        if_req_i = 1'b1;
        if_pc_i  = pc;
        cyc();
        checks++;
        if (mem_req_o !== 1'b1 || mem_pc_o !== pc || busy_o !== 1'b1 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_req: pc=%h mem_req=%b mem_pc=%h busy=%b valid=%b, expected 1/%h/1/0",
                     pc, mem_req_o, mem_pc_o, busy_o, inst_valid_o, pc);
        end
        cyc();
        checks++;
        if (mem_req_o !== 1'b1 || mem_pc_o !== pc || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL fill_hold: mem_req=%b mem_pc=%h busy=%b, expected 1/%h/1",
                     mem_req_o, mem_pc_o, busy_o, pc);
        end
        mem_inst_ready_i = 1'b1;
        mem_inst_i       = data;
        exp_q.push_back(data);
        cyc();
        idle_inputs();
        checks++;
        if (inst_valid_o !== 1'b1 || mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_done: valid=%b mem_req=%b busy=%b, expected 1/0/0",
                     inst_valid_o, mem_req_o, busy_o);
        end
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rdy = 1'b0;
        idle_inputs();
        if_pc_i    = 32'h0;
        mem_inst_i = 32'h0;
        cyc();
        cyc();
        checks++;
        if ({inst_valid_o, busy_o, mem_req_o, mem_jump_o} !== 4'b0 || inst_o !== 32'h0 || mem_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: v/b/r/j=%b inst=%h mem_pc=%h, expected all zero",
                     {inst_valid_o, busy_o, mem_req_o, mem_jump_o}, inst_o, mem_pc_o);
        end
        rst = 1'b1;
        rdy = 1'b1;
        cyc();
    endtask

    task automatic test_miss_fill();
        fill(32'h0000_0004, 32'h0050_0093);
    endtask

    task automatic test_hit();
        if_req_i = 1'b1;
        if_pc_i  = 32'h4;
        exp_q.push_back(32'h0050_0093);
        cyc();
        checks++;
        if (inst_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_single: valid=%b mem_req=%b, expected 1/0", inst_valid_o, mem_req_o);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0050_0093);
            cyc();
            checks++;
            if (inst_valid_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL hit_b2b[%0d]: valid=%b busy=%b, expected 1/0", i, inst_valid_o, busy_o);
            end
        end
        idle_inputs();
        cyc();
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_end: valid=%b, expected 0", inst_valid_o);
        end
    endtask

    task automatic test_conflict();
        fill(32'h0000_0104, 32'h1111_1111);
        fill(32'h0000_0004, 32'h0050_0093);
        if_req_i = 1'b1;
        if_pc_i  = 32'h104;
        cyc();
        idle_inputs();
        checks++;
        if (mem_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL conflict_evict: mem_req=%b valid=%b, expected 1/0", mem_req_o, inst_valid_o);
        end
        if_jump_i = 1'b1;
        cyc();
        if_jump_i = 1'b0;
        cyc();
    endtask

    task automatic test_jump();
        if_req_i = 1'b1;
        if_pc_i  = 32'h8;
        cyc();
        cyc();
        if_jump_i = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (mem_jump_o !== 1'b1 || mem_req_o !== 1'b0 || busy_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL jump_pulse: jump=%b req=%b busy=%b valid=%b, expected 1/0/0/0",
                     mem_jump_o, mem_req_o, busy_o, inst_valid_o);
        end
        cyc();
        checks++;
        if (mem_jump_o !== 1'b0) begin
            errors++;
            $display("FAIL jump_single: jump=%b, expected 0", mem_jump_o);
        end
        mem_inst_ready_i = 1'b1;
        mem_inst_i       = 32'hDEAD_BEEF;
        cyc();
        mem_inst_ready_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL jump_stale: valid=%b req=%b, expected 0/0", inst_valid_o, mem_req_o);
        end
        cyc();
        fill(32'h0000_0008, 32'h2222_2222);
    endtask

    task automatic test_ready_jump();
        if_req_i = 1'b1;
        if_pc_i  = 32'hC;
        cyc();
        mem_inst_ready_i = 1'b1;
        mem_inst_i       = 32'h3333_3333;
        if_jump_i        = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (mem_jump_o !== 1'b1 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rj_pulse: jump=%b valid=%b, expected 1/0", mem_jump_o, inst_valid_o);
        end
        cyc();
        if_req_i = 1'b1;
        if_pc_i  = 32'hC;
        exp_q.push_back(32'h3333_3333);
        cyc();
        idle_inputs();
        checks++;
        if (inst_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rj_hit: valid=%b req=%b, expected 1/0", inst_valid_o, mem_req_o);
        end
        cyc();
    endtask

    task automatic test_rdy_stall();
        if_req_i = 1'b1;
        if_pc_i  = 32'h10;
        cyc();
        rdy              = 1'b0;
        mem_inst_ready_i = 1'b1;
        mem_inst_i       = 32'h4444_4444;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (mem_req_o !== 1'b1 || mem_pc_o !== 32'h10 || busy_o !== 1'b1 || inst_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_miss[%0d]: req=%b pc=%h busy=%b valid=%b, expected 1/00000010/1/0",
                         i, mem_req_o, mem_pc_o, busy_o, inst_valid_o);
            end
        end
        rdy = 1'b1;
        exp_q.push_back(32'h4444_4444);
        cyc();
        rdy = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (inst_valid_o !== 1'b1 || inst_o !== 32'h4444_4444) begin
                errors++;
                $display("FAIL stall_pulse[%0d]: valid=%b inst=%h, expected 1/44444444", i, inst_valid_o, inst_o);
            end
        end
        rdy = 1'b1;
        cyc();
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b, expected 0", inst_valid_o);
        end
    endtask

    task automatic test_reset_mid_miss();
        if_req_i = 1'b1;
        if_pc_i  = 32'h14;
        cyc();
        idle_inputs();
        rst = 1'b0;
        rdy = 1'b0;
        cyc();
        checks++;
        if ({inst_valid_o, busy_o, mem_req_o, mem_jump_o} !== 4'b0 || mem_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: v/b/r/j=%b mem_pc=%h, expected all zero",
                     {inst_valid_o, busy_o, mem_req_o, mem_jump_o}, mem_pc_o);
        end
        rst = 1'b1;
        rdy = 1'b1;
        cyc();
        fill(32'h0000_0004, 32'h0050_0093);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_jump();
        test_ready_jump();
        test_rdy_stall();
        test_reset_mid_miss();
        repeat (3) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected instructions never delivered, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
